// File: rtl/pe_ctrl_if.sv
// ============================================================================
//  Module      : pe_ctrl_if
//  Description : Enable/address bundle between the engine FSM and pe_controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pe_ctrl_if #(
    parameter int W_PE_ADDR_WIDTH   = 2,
    parameter int O_PE_ADDR_WIDTH   = 2,
    parameter int I_PE_ADDR_WIDTH   = 3,
    parameter int BLOCK_COUNT_WIDTH = 2
);
    logic                         EN_W;
    logic                         EN_I;
    logic                         EN_O_In;
    logic                         EN_O_Out;

    logic [W_PE_ADDR_WIDTH-1:0]   W_PEAddr;
    logic [I_PE_ADDR_WIDTH-1:0]   I_PEAddr;
    logic [O_PE_ADDR_WIDTH-1:0]   O_In_PEAddr;
    logic [O_PE_ADDR_WIDTH-1:0]   O_Out_PEAddr;

    logic [BLOCK_COUNT_WIDTH-1:0] I_Block_Counter;
    logic [BLOCK_COUNT_WIDTH-1:0] O_In_Block_Counter;
    logic [BLOCK_COUNT_WIDTH-1:0] O_Out_Block_Counter;

    logic                         I_BLOCK_EQUAL_TO_ZERO;
    logic                         O_IN_BLOCK_EQUAL_TO_ZERO;
    logic                         O_Out_BLOCK_EQUAL_TO_ZERO;
    logic                         I_BLOCK_EQUAL_TO_BLOCK_COUNT;
    logic                         O_IN_BLOCK_EQUAL_TO_BLOCK_COUNT;
    logic                         O_OUT_BLOCK_EQUAL_TO_BLOCK_COUNT;

    modport master (
        output EN_W, EN_I, EN_O_In, EN_O_Out,
        input  W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr,
        input  I_Block_Counter, O_In_Block_Counter, O_Out_Block_Counter,
        input  I_BLOCK_EQUAL_TO_ZERO, O_IN_BLOCK_EQUAL_TO_ZERO, O_Out_BLOCK_EQUAL_TO_ZERO,
        input  I_BLOCK_EQUAL_TO_BLOCK_COUNT, O_IN_BLOCK_EQUAL_TO_BLOCK_COUNT,
        input  O_OUT_BLOCK_EQUAL_TO_BLOCK_COUNT
    );

    modport slave (
        input  EN_W, EN_I, EN_O_In, EN_O_Out,
        output W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr,
        output I_Block_Counter, O_In_Block_Counter, O_Out_Block_Counter,
        output I_BLOCK_EQUAL_TO_ZERO, O_IN_BLOCK_EQUAL_TO_ZERO, O_Out_BLOCK_EQUAL_TO_ZERO,
        output I_BLOCK_EQUAL_TO_BLOCK_COUNT, O_IN_BLOCK_EQUAL_TO_BLOCK_COUNT,
        output O_OUT_BLOCK_EQUAL_TO_BLOCK_COUNT
    );
endinterface

`default_nettype wire

// File: rtl/pe_controller.sv
// ============================================================================
//  Module      : pe_controller
//  Description : PE-select address sequencer with per-stream block counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_controller #(
    parameter int W_PE_GROUP_SIZE   = 4,
    parameter int O_PE_GROUP_SIZE   = 4,
    parameter int I_PE_GROUP_SIZE   = W_PE_GROUP_SIZE + O_PE_GROUP_SIZE - 1,
    parameter int W_PE_ADDR_WIDTH   = 2,
    parameter int O_PE_ADDR_WIDTH   = 2,
    parameter int I_PE_ADDR_WIDTH   = 3,
    parameter int BLOCK_COUNT       = 4,
    parameter int BLOCK_COUNT_WIDTH = 2
) (
    input  wire logic    clk,
    input  wire logic    aclr,
    input  wire logic    sclr,
    pe_ctrl_if.slave     bus
);

    localparam logic [W_PE_ADDR_WIDTH-1:0]   c_W_LAST   = W_PE_ADDR_WIDTH'(W_PE_GROUP_SIZE - 1);
    localparam logic [I_PE_ADDR_WIDTH-1:0]   c_I_LAST   = I_PE_ADDR_WIDTH'(I_PE_GROUP_SIZE - 1);
    localparam logic [O_PE_ADDR_WIDTH-1:0]   c_O_LAST   = O_PE_ADDR_WIDTH'(O_PE_GROUP_SIZE - 1);
    localparam logic [BLOCK_COUNT_WIDTH-1:0] c_BLK_LAST = BLOCK_COUNT_WIDTH'(BLOCK_COUNT - 1);

    logic [W_PE_ADDR_WIDTH-1:0]   r_w_addr;
    logic [I_PE_ADDR_WIDTH-1:0]   r_i_addr;
    logic [O_PE_ADDR_WIDTH-1:0]   r_oi_addr;
    logic [O_PE_ADDR_WIDTH-1:0]   r_oo_addr;
    logic [BLOCK_COUNT_WIDTH-1:0] r_i_blk;
    logic [BLOCK_COUNT_WIDTH-1:0] r_oi_blk;
    logic [BLOCK_COUNT_WIDTH-1:0] r_oo_blk;

    logic w_w_wrap;
    logic w_i_wrap;
    logic w_oi_wrap;
    logic w_oo_wrap;

    // A wrap is an enabled advance out of the last PE; it is also the block step.
    assign w_w_wrap  = bus.EN_W     && (r_w_addr  == c_W_LAST);
    assign w_i_wrap  = bus.EN_I     && (r_i_addr  == c_I_LAST);
    assign w_oi_wrap = bus.EN_O_In  && (r_oi_addr == c_O_LAST);
    assign w_oo_wrap = bus.EN_O_Out && (r_oo_addr == c_O_LAST);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_w_addr  <= '0;
            r_i_addr  <= '0;
            r_oi_addr <= '0;
            r_oo_addr <= '0;
            r_i_blk   <= '0;
            r_oi_blk  <= '0;
            r_oo_blk  <= '0;
        end else if (sclr) begin
            r_w_addr  <= '0;
            r_i_addr  <= '0;
            r_oi_addr <= '0;
            r_oo_addr <= '0;
            r_i_blk   <= '0;
            r_oi_blk  <= '0;
            r_oo_blk  <= '0;
        end else begin
            if (bus.EN_W) begin
                r_w_addr <= w_w_wrap ? '0 : r_w_addr + 1'b1;
            end
            if (bus.EN_I) begin
                r_i_addr <= w_i_wrap ? '0 : r_i_addr + 1'b1;
            end
            if (bus.EN_O_In) begin
                r_oi_addr <= w_oi_wrap ? '0 : r_oi_addr + 1'b1;
            end
            if (bus.EN_O_Out) begin
                r_oo_addr <= w_oo_wrap ? '0 : r_oo_addr + 1'b1;
            end
            if (w_i_wrap) begin
                r_i_blk <= (r_i_blk == c_BLK_LAST) ? '0 : r_i_blk + 1'b1;
            end
            if (w_oi_wrap) begin
                r_oi_blk <= (r_oi_blk == c_BLK_LAST) ? '0 : r_oi_blk + 1'b1;
            end
            if (w_oo_wrap) begin
                r_oo_blk <= (r_oo_blk == c_BLK_LAST) ? '0 : r_oo_blk + 1'b1;
            end
        end
    end

    assign bus.W_PEAddr            = r_w_addr;
    assign bus.I_PEAddr            = r_i_addr;
    assign bus.O_In_PEAddr         = r_oi_addr;
    assign bus.O_Out_PEAddr        = r_oo_addr;
    assign bus.I_Block_Counter     = r_i_blk;
    assign bus.O_In_Block_Counter  = r_oi_blk;
    assign bus.O_Out_Block_Counter = r_oo_blk;

    assign bus.I_BLOCK_EQUAL_TO_ZERO            = (r_i_blk  == '0);
    assign bus.O_IN_BLOCK_EQUAL_TO_ZERO         = (r_oi_blk == '0);
    assign bus.O_Out_BLOCK_EQUAL_TO_ZERO        = (r_oo_blk == '0);
    assign bus.I_BLOCK_EQUAL_TO_BLOCK_COUNT     = (r_i_blk  == c_BLK_LAST);
    assign bus.O_IN_BLOCK_EQUAL_TO_BLOCK_COUNT  = (r_oi_blk == c_BLK_LAST);
    assign bus.O_OUT_BLOCK_EQUAL_TO_BLOCK_COUNT = (r_oo_blk == c_BLK_LAST);

endmodule

`default_nettype wire

// File: tb/tb_pe_controller.sv
// ============================================================================
//  Module      : tb_pe_controller
//  Description : Scoreboard bench for pe_controller address/block sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_controller;

    typedef struct packed {
        logic [1:0] w;
        logic [2:0] i;
        logic [1:0] oi;
        logic [1:0] oo;
        logic [1:0] ib;
        logic [1:0] oib;
        logic [1:0] oob;
        logic       iz;
        logic       oiz;
        logic       ooz;
        logic       il;
        logic       oil;
        logic       ool;
    } snap_t;

    logic clk;
    logic clk_run;
    logic aclr;
    logic sclr;

    int   total;
    int   bad;
    int   cnt_w;
    int   cnt_i;
    int   cnt_oi;
    int   cnt_oo;

    snap_t sb[$];
    snap_t got;
    snap_t exp_s;

    pe_ctrl_if bus ();

    pe_controller dut (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (bus)
    );

    always #5 clk = clk_run ? ~clk : 1'b0;

    // Expected outputs follow from how many advances each stream has seen since the last clear.
    function automatic snap_t model_snap();
        snap_t s;
        s.w   = 2'(cnt_w % 4);
        s.i   = 3'(cnt_i % 7);
        s.oi  = 2'(cnt_oi % 4);
        s.oo  = 2'(cnt_oo % 4);
        s.ib  = 2'((cnt_i / 7) % 4);
        s.oib = 2'((cnt_oi / 4) % 4);
        s.oob = 2'((cnt_oo / 4) % 4);
        s.iz  = (s.ib == 2'd0);
        s.oiz = (s.oib == 2'd0);
        s.ooz = (s.oob == 2'd0);
        s.il  = (s.ib == 2'd3);
        s.oil = (s.oib == 2'd3);
        s.ool = (s.oob == 2'd3);
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.w   = bus.W_PEAddr;
        s.i   = bus.I_PEAddr;
        s.oi  = bus.O_In_PEAddr;
        s.oo  = bus.O_Out_PEAddr;
        s.ib  = bus.I_Block_Counter;
        s.oib = bus.O_In_Block_Counter;
        s.oob = bus.O_Out_Block_Counter;
        s.iz  = bus.I_BLOCK_EQUAL_TO_ZERO;
        s.oiz = bus.O_IN_BLOCK_EQUAL_TO_ZERO;
        s.ooz = bus.O_Out_BLOCK_EQUAL_TO_ZERO;
        s.il  = bus.I_BLOCK_EQUAL_TO_BLOCK_COUNT;
        s.oil = bus.O_IN_BLOCK_EQUAL_TO_BLOCK_COUNT;
        s.ool = bus.O_OUT_BLOCK_EQUAL_TO_BLOCK_COUNT;
        return s;
    endfunction

    // Drive one clock edge; the expected post-edge state is queued before the edge.
    task automatic advance(input logic [3:0] en, input logic clr);
        bus.EN_W     = en[3];
        bus.EN_I     = en[2];
        bus.EN_O_In  = en[1];
        bus.EN_O_Out = en[0];
        sclr         = clr;
        if (clr) begin
            cnt_w = 0; cnt_i = 0; cnt_oi = 0; cnt_oo = 0;
        end else begin
            cnt_w  += int'(en[3]);
            cnt_i  += int'(en[2]);
            cnt_oi += int'(en[1]);
            cnt_oo += int'(en[0]);
        end
        sb.push_back(model_snap());
        @(posedge clk);
        #1;
        bus.EN_W = 1'b0; bus.EN_I = 1'b0; bus.EN_O_In = 1'b0; bus.EN_O_Out = 1'b0;
        sclr = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        cnt_w = 0; cnt_i = 0; cnt_oi = 0; cnt_oo = 0;
        sb.push_back(model_snap());
        #3;
        got = sample(); exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin
            bad++;
            $display("FAIL reset: got=%h want=%h", got, exp_s);
        end
        #4;
        aclr    = 1'b1;
        clk_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_enables();
        for (int k = 0; k < 8; k++) begin
            advance(4'b1111, 1'b0);
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL all_en edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
    endtask

    task automatic test_i_blocks();
        advance(4'b0000, 1'b1);
        got = sample(); exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin
            bad++;
            $display("FAIL i_blocks clear: got=%h want=%h", got, exp_s);
        end
        for (int k = 0; k < 28; k++) begin
            advance(4'b0100, 1'b0);
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL i_blocks edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
    endtask

    task automatic test_independent();
        advance(4'b0000, 1'b1);
        void'(sb.pop_front());
        for (int k = 0; k < 5; k++) begin
            advance(4'b0010, 1'b0);
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL independent edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
        for (int k = 0; k < 3; k++) begin
            advance(4'b0000, 1'b0);
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL hold edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
    endtask

    task automatic test_sclr();
        advance(4'b0000, 1'b1);
        void'(sb.pop_front());
        for (int k = 0; k < 18; k++) begin
            advance(4'b0100, 1'b0);
            void'(sb.pop_front());
        end
        got = sample(); exp_s = model_snap(); total++;
        if (got.i !== 3'd4 || got.ib !== 2'd2 || got !== exp_s) begin
            bad++;
            $display("FAIL sclr setup: got=%h want=%h", got, exp_s);
        end
        advance(4'b1111, 1'b1);
        got = sample(); exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin
            bad++;
            $display("FAIL sclr clear: got=%h want=%h", got, exp_s);
        end
        advance(4'b0100, 1'b0);
        got = sample(); exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin
            bad++;
            $display("FAIL sclr resume: got=%h want=%h", got, exp_s);
        end
    endtask

    task automatic test_aclr();
        for (int k = 0; k < 6; k++) begin
            advance(4'b1111, 1'b0);
            void'(sb.pop_front());
        end
        #2;
        aclr = 1'b0;
        cnt_w = 0; cnt_i = 0; cnt_oi = 0; cnt_oo = 0;
        sb.push_back(model_snap());
        #1;
        got = sample(); exp_s = sb.pop_front(); total++;
        if (got !== exp_s) begin
            bad++;
            $display("FAIL aclr async: got=%h want=%h", got, exp_s);
        end
        #1;
        aclr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            advance(4'b1111, 1'b0);
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL aclr resume edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            advance(4'($urandom_range(15)), ($urandom_range(31) == 0));
            got = sample(); exp_s = sb.pop_front(); total++;
            if (got !== exp_s) begin
                bad++;
                $display("FAIL random edge %0d: got=%h want=%h", k + 1, got, exp_s);
            end
        end
    endtask

    initial begin
        clk = 1'b0; clk_run = 1'b0; aclr = 1'b0; sclr = 1'b0;
        total = 0; bad = 0;
        bus.EN_W = 1'b0; bus.EN_I = 1'b0; bus.EN_O_In = 1'b0; bus.EN_O_Out = 1'b0;
        test_reset();
        test_all_enables();
        test_i_blocks();
        test_independent();
        test_sclr();
        test_aclr();
        test_back_to_back();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover: got=%0d want=0", sb.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
